// File: rtl/fir_pkg.sv
// fir_pkg: shared definitions for the FIR sequencer slice.
//   state_t   : sequencer states (IDLE, MAC)
//   N_DEF     : default data width (two's complement, shared with Aritmetica)
//   FRAC_DEF  : default fractional bits (1.0 = 2^FRAC_DEF)
//   ONE       : 1.0 in Q(FRAC_DEF)
//   DEF_COEF  : reset coefficient table in Q(FRAC_DEF); tap 0 = 1.0, rest 0,
//               so a freshly reset filter is a pass-through
//   def_coef  : reads the table and rescales it to another FRAC
package fir_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        MAC  = 1'b1
    } state_t;

    localparam int unsigned N_DEF    = 25;
    localparam int unsigned FRAC_DEF = 10;
    localparam int unsigned TAPS_MAX = 16;

    localparam logic [N_DEF-1:0] ONE = N_DEF'(1) << FRAC_DEF;

    localparam logic signed [N_DEF-1:0] DEF_COEF [TAPS_MAX] = '{0: ONE, default: '0};

    // Table entries are stored in Q(FRAC_DEF); shift them to the instance's FRAC.
    function automatic logic [63:0] def_coef(input int unsigned k, input int unsigned frac);
        logic signed [63:0] v;
        v = longint'(DEF_COEF[k]);
        if (frac >= FRAC_DEF)
            return v <<< (frac - FRAC_DEF);
        return v >>> (FRAC_DEF - frac);
    endfunction

endpackage

// File: rtl/secuenciador_fir_linea_retardo.sv
// linea_retardo: sample delay line and coefficient store for secuenciador_fir.
// Configuration macro: SECUENCIADOR_COEF_WRITE_EN (writable coefficients).
// Ports:
//   clk, reset_n  : clock, asynchronous active-low reset
//   shift_en      : shift the delay line, in_sample enters at tap 0
//   in_sample     : new sample x[n]
//   coef_wr       : coefficient write strobe (already gated to IDLE by the top)
//   coef_addr     : coefficient index; indices >= TAPS never match a tap
//   coef_data     : coefficient value
//   idx           : tap being processed
//   coef_rd       : coef[idx]
//   sample_rd     : x[n-idx]
module linea_retardo
    import fir_pkg::*;
#(
    parameter int unsigned N    = N_DEF,
    parameter int unsigned FRAC = FRAC_DEF,
    parameter int unsigned TAPS = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     shift_en,
    input  logic [N-1:0]             in_sample,
    input  logic                     coef_wr,
    input  logic [$clog2(TAPS)-1:0]  coef_addr,
    input  logic [N-1:0]             coef_data,
    input  logic [$clog2(TAPS)-1:0]  idx,
    output logic [N-1:0]             coef_rd,
    output logic [N-1:0]             sample_rd
);

    localparam int unsigned AW = $clog2(TAPS);

    logic [N-1:0] linea [TAPS];
    logic [N-1:0] coef  [TAPS];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            linea <= '{default: '0};
        end else if (shift_en) begin
            linea[0] <= in_sample;
            for (int unsigned i = 1; i < TAPS; i++)
                linea[i] <= linea[i-1];
        end
    end

`ifdef SECUENCIADOR_COEF_WRITE_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < TAPS; i++)
                coef[i] <= N'(def_coef(i, FRAC));
        end else begin
            for (int unsigned i = 0; i < TAPS; i++)
                if (coef_wr && coef_addr == AW'(i))
                    coef[i] <= coef_data;
        end
    end
`else
    for (genvar g = 0; g < TAPS; g++) begin : g_coef_fijo
        assign coef[g] = N'(def_coef(g, FRAC));
    end

    logic unused_wr;
    assign unused_wr = ^{coef_wr, coef_addr, coef_data};
`endif

    always_comb begin
        coef_rd   = '0;
        sample_rd = '0;
        for (int unsigned i = 0; i < TAPS; i++) begin
            if (idx == AW'(i)) begin
                coef_rd   = coef[i];
                sample_rd = linea[i];
            end
        end
    end

endmodule

// File: rtl/secuenciador_fir.sv
// secuenciador_fir: sequences the combinational Aritmetica MAC stage over TAPS
// taps, one tap per cycle, to form a fixed-point FIR filter.
// Configuration macro: SECUENCIADOR_COEF_WRITE_EN (coefficient write port live).
// Ports:
//   clk, reset_n      : clock, asynchronous active-low reset
//   in_valid/in_ready : sample handshake, accepted only in IDLE
//   in_sample         : input sample x[n]
//   out_valid         : one-cycle pulse, out_sample is new
//   out_sample        : filtered sample y[n]
//   busy              : MAC sequence in progress
//   arit_const        : to Constantes_G, running partial sum
//   arit_mult         : to Multip_G, coef[idx]
//   arit_entrada      : to Entrada_G, x[n-idx]
//   arit_valores      : from Valores, partial sum + coef * sample
//   coef_we/addr/data : coefficient write port
module secuenciador_fir
    import fir_pkg::*;
#(
    parameter int unsigned N    = N_DEF,
    parameter int unsigned FRAC = FRAC_DEF,
    parameter int unsigned TAPS = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N-1:0]             in_sample,
    output logic                     out_valid,
    output logic [N-1:0]             out_sample,
    output logic                     busy,
    output logic [N-1:0]             arit_const,
    output logic [N-1:0]             arit_mult,
    output logic [N-1:0]             arit_entrada,
    input  logic [N-1:0]             arit_valores,
    input  logic                     coef_we,
    input  logic [$clog2(TAPS)-1:0]  coef_addr,
    input  logic [N-1:0]             coef_data
);

    localparam int unsigned AW = $clog2(TAPS);

    state_t        state;
    logic [N-1:0]  acc;
    logic [AW-1:0] idx;
    logic [N-1:0]  coef_rd;
    logic [N-1:0]  sample_rd;
    logic [N-1:0]  hold_const;
    logic [N-1:0]  hold_mult;
    logic [N-1:0]  hold_entrada;
    logic          accept;
    logic          coef_wr;

    assign in_ready = (state == IDLE);
    assign busy     = (state == MAC);
    assign accept   = in_ready && in_valid;
    // Coefficients only change between samples, never mid-sequence.
    assign coef_wr  = coef_we && in_ready;

    linea_retardo #(
        .N    (N),
        .FRAC (FRAC),
        .TAPS (TAPS)
    ) u_linea (
        .clk       (clk),
        .reset_n   (reset_n),
        .shift_en  (accept),
        .in_sample (in_sample),
        .coef_wr   (coef_wr),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .idx       (idx),
        .coef_rd   (coef_rd),
        .sample_rd (sample_rd)
    );

    // The MAC operands are live during MAC; the hold registers keep the last
    // driven values so the Aritmetica inputs stay still while IDLE.
    assign arit_const   = busy ? acc       : hold_const;
    assign arit_mult    = busy ? coef_rd   : hold_mult;
    assign arit_entrada = busy ? sample_rd : hold_entrada;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            acc          <= '0;
            idx          <= '0;
            out_valid    <= 1'b0;
            out_sample   <= '0;
            hold_const   <= '0;
            hold_mult    <= '0;
            hold_entrada <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        acc   <= '0;
                        idx   <= '0;
                        state <= MAC;
                    end
                end
                MAC: begin
                    acc          <= arit_valores;
                    idx          <= idx + 1'b1;
                    hold_const   <= acc;
                    hold_mult    <= coef_rd;
                    hold_entrada <= sample_rd;
                    if (idx == AW'(TAPS - 1)) begin
                        out_sample <= arit_valores;
                        out_valid  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_secuenciador_fir.sv
`timescale 1ns/1ps
module tb_secuenciador_fir;

    localparam int N    = 25;
    localparam int FRAC = 10;
    localparam int TAPS = 4;
    localparam int AW   = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [N-1:0]  in_sample = '0;
    logic          out_valid;
    logic [N-1:0]  out_sample;
    logic          busy;
    logic [N-1:0]  arit_const;
    logic [N-1:0]  arit_mult;
    logic [N-1:0]  arit_entrada;
    logic [N-1:0]  arit_valores;
    logic          coef_we = 1'b0;
    logic [AW-1:0] coef_addr = '0;
    logic [N-1:0]  coef_data = '0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    secuenciador_fir #(.N(N), .FRAC(FRAC), .TAPS(TAPS)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sample    (in_sample),
        .out_valid    (out_valid),
        .out_sample   (out_sample),
        .busy         (busy),
        .arit_const   (arit_const),
        .arit_mult    (arit_mult),
        .arit_entrada (arit_entrada),
        .arit_valores (arit_valores),
        .coef_we      (coef_we),
        .coef_addr    (coef_addr),
        .coef_data    (coef_data)
    );

    // Reference Aritmetica: Valores = Constantes + (Multip*Entrada)>>>FRAC
    function automatic logic [N-1:0] term(input logic [N-1:0] c, input logic [N-1:0] x);
        logic signed [N-1:0] sc;
        logic signed [N-1:0] sx;
        longint p;
        sc = c;
        sx = x;
        p = longint'(sc) * longint'(sx);
        return N'(p >>> FRAC);
    endfunction

    always_comb arit_valores = arit_const + term(arit_mult, arit_entrada);

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail_timeout(input string nm);
        total++;
        bad++;
        $display("FAIL %s: timed out, got no event expected one", nm);
    endtask

    // Behavioural model: sample history, coefficient array and a countdown
    // of the remaining MAC cycles for the sample in flight.
    logic [N-1:0] m_coef [TAPS];
    logic [N-1:0] m_hist [TAPS];
    int           m_left;
    logic [N-1:0] m_y;
    logic         m_ov;
    logic [N-1:0] m_out;

    function automatic logic [N-1:0] partial(input int k);
        logic [N-1:0] s;
        s = '0;
        for (int j = 0; j < k; j++)
            s = s + term(m_coef[j], m_hist[j]);
        return s;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < TAPS; k++) begin
                m_coef[k] = (k == 0) ? N'(1 << FRAC) : '0;
                m_hist[k] = '0;
            end
            m_left = 0;
            m_ov   = 1'b0;
            m_out  = '0;
            m_y    = '0;
        end else begin
            m_ov = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_ov  = 1'b1;
                    m_out = m_y;
                end
            end else begin
`ifdef SECUENCIADOR_COEF_WRITE_EN
                if (coef_we)
                    m_coef[coef_addr] = coef_data;
`endif
                if (in_valid) begin
                    for (int k = TAPS - 1; k > 0; k--)
                        m_hist[k] = m_hist[k-1];
                    m_hist[0] = in_sample;
                    m_y    = partial(TAPS);
                    m_left = TAPS;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            chk("in_ready", {63'd0, in_ready}, {63'd0, m_left == 0});
            chk("busy", {63'd0, busy}, {63'd0, m_left != 0});
            chk("out_valid", {63'd0, out_valid}, {63'd0, m_ov});
            chk("out_sample", 64'(out_sample), 64'(m_out));
            if (m_left > 0) begin
                chk("arit_mult", 64'(arit_mult), 64'(m_coef[TAPS - m_left]));
                chk("arit_entrada", 64'(arit_entrada), 64'(m_hist[TAPS - m_left]));
                chk("arit_const", 64'(arit_const), 64'(partial(TAPS - m_left)));
            end
        end
    end

    // All stimulus tasks start and end on a falling edge.
    task automatic send(input logic [N-1:0] s);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) fail_timeout("send");
        in_valid  = 1'b1;
        in_sample = s;
        @(negedge clk);
        in_valid  = 1'b0;
    endtask

    task automatic wait_out(input string nm, input logic [N-1:0] exp, output int n);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) fail_timeout(nm);
        else chk(nm, 64'(out_sample), 64'(exp));
    endtask

    task automatic write_coef(input logic [AW-1:0] a, input logic [N-1:0] d);
        coef_we   = 1'b1;
        coef_addr = a;
        coef_data = d;
        @(negedge clk);
        coef_we   = 1'b0;
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_ov"}, {63'd0, out_valid}, 64'd0);
        chk({nm, "_os"}, 64'(out_sample), 64'd0);
        chk({nm, "_rdy"}, {63'd0, in_ready}, 64'd1);
        chk({nm, "_busy"}, {63'd0, busy}, 64'd0);
        chk({nm, "_arit"}, 64'({arit_const, arit_mult, arit_entrada}), 64'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
    endtask

    logic [N-1:0] imp_exp [5];
    int lat;
    int acc_cnt;
    int last_acc;

    initial begin
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("rst_held");
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("rst_rel");

        // Pass-through, latency and pulse width
        send(N'(1536));
        wait_out("pass_1536", N'(1536), lat);
        chk("latency", 64'(lat), 64'(TAPS));
        @(negedge clk);
        chk("pulse_width", {63'd0, out_valid}, 64'd0);

        // Negative: -1.0 through 1.0 coefficient
        send(25'h1FFFC00);
        wait_out("neg_one", 25'h1FFFC00, lat);

        // Coefficient write while busy must be ignored
        send(N'(3000));
        write_coef(2'd0, '0);
        wait_out("we_busy", N'(3000), lat);
        send(N'(777));
        wait_out("we_busy_next", N'(777), lat);

        // Backpressure: in_valid held high for 20 cycles
        acc_cnt  = 0;
        last_acc = -1;
        in_sample = N'(100);
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            if (in_ready) begin
                if (last_acc >= 0) chk("bp_gap", 64'(i - last_acc), 64'(TAPS + 1));
                acc_cnt++;
                last_acc = i;
            end
            @(negedge clk);
            if (last_acc == i) in_sample = in_sample + 1'b1;
        end
        in_valid = 1'b0;
        chk("bp_count", 64'(acc_cnt), 64'd4);
        repeat (3) @(negedge clk);

        // Randomized traffic, coefficient writes land in IDLE or busy
        for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(2)) @(negedge clk);
            if ($urandom_range(2) == 0)
                write_coef(AW'($urandom_range(TAPS - 1)), N'($urandom_range(4095)) - N'(2048));
            send(N'($urandom_range(32767)) - N'(16384));
        end
        repeat (TAPS + 3) @(negedge clk);

        // Impulse response after a clean reset
        do_reset();
`ifdef SECUENCIADOR_COEF_WRITE_EN
        write_coef(2'd0, N'(1024));
        write_coef(2'd1, N'(512));
        write_coef(2'd2, N'(256));
        write_coef(2'd3, N'(128));
        imp_exp = '{N'(1024), N'(512), N'(256), N'(128), N'(0)};
`else
        imp_exp = '{N'(1024), N'(0), N'(0), N'(0), N'(0)};
`endif
        for (int i = 0; i < 5; i++) begin
            send((i == 0) ? N'(1024) : N'(0));
            wait_out("impulse", imp_exp[i], lat);
        end

        // Reset in the middle of a MAC sequence (idx == 2)
        send(N'(5000));
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst_mid");
        @(posedge clk);
        #1 reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("no_pulse", {63'd0, out_valid}, 64'd0);
        end
        for (int i = 0; i < 4; i++) begin
            send((i == 0) ? N'(1024) : N'(0));
            wait_out("post_rst_imp", (i == 0) ? N'(1024) : N'(0), lat);
        end
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
